// File: rtl/dump_ctrl_pkg.sv
// ============================================================================
// Module      : dump_ctrl_pkg
// Description : Shared constants, address type and dump state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dump_ctrl_pkg;

    localparam int unsigned c_DEPTH = 512;
    localparam int unsigned c_DW    = 8;
    localparam int unsigned c_AW    = $clog2(c_DEPTH);

    typedef logic [c_AW-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dump_ctrl_if.sv
// ============================================================================
// Module      : dump_ctrl_if
// Description : Request, capture, RAM and transmitter signals of the dump unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dump_ctrl_if
    import dump_ctrl_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int DW    = c_DW
);
    localparam int AW = $clog2(DEPTH);

    logic          dump_req;
    logic [1:0]    dump_chan;
    logic          capture_done;
    logic [AW-1:0] trace_end;
    logic [AW-1:0] cap_addr;
    logic          cap_en;
    logic          cap_we;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic          ram_we;
    logic [1:0]    ram_sel;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          tx_done;
    logic          dump_busy;
    logic          clr_capture_done;
    logic          dump_err;

    modport master (
        output dump_req, dump_chan, capture_done, trace_end,
        output cap_addr, cap_en, cap_we, ram_rdata, tx_done,
        input  ram_addr, ram_en, ram_we, ram_sel, tx_data, tx_start,
        input  dump_busy, clr_capture_done, dump_err
    );

    modport slave (
        input  dump_req, dump_chan, capture_done, trace_end,
        input  cap_addr, cap_en, cap_we, ram_rdata, tx_done,
        output ram_addr, ram_en, ram_we, ram_sel, tx_data, tx_start,
        output dump_busy, clr_capture_done, dump_err
    );

endinterface

`default_nettype wire

// File: rtl/dump_ctrl_ram_port_mux.sv
// ============================================================================
// Module      : ram_port_mux
// Description : Shares one RAM port between capture and dump; dump never writes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_port_mux
    import dump_ctrl_pkg::*;
#(
    parameter int AW = c_AW
) (
    input  wire logic          i_dump_busy,
    input  wire logic [AW-1:0] i_cap_addr,
    input  wire logic          i_cap_en,
    input  wire logic          i_cap_we,
    input  wire logic [AW-1:0] i_dump_addr,
    input  wire logic          i_dump_en,
    output logic      [AW-1:0] o_ram_addr,
    output logic               o_ram_en,
    output logic               o_ram_we
);

    always_comb begin
        o_ram_addr = i_cap_addr;
        o_ram_en   = i_cap_en;
        o_ram_we   = i_cap_we;
        if (i_dump_busy) begin
            o_ram_addr = i_dump_addr;
            o_ram_en   = i_dump_en;
            o_ram_we   = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dump_ctrl.sv
// ============================================================================
// Module      : dump_ctrl
// Description : Streams a captured trace, oldest sample first, to a byte transmitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dump_ctrl
    import dump_ctrl_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int DW    = c_DW
) (
    input  wire logic clk,
    input  wire logic rst,
    dump_ctrl_if.slave bus
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int unsigned c_LAST_INT = DEPTH - 1;
    localparam logic [AW:0] c_LAST     = c_LAST_INT[AW:0];

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_cnt;
    logic [1:0]    r_chan;
    logic [DW-1:0] r_tx_data;
    logic          r_tx_start;
    logic          r_clr;
    logic          r_err;
    logic          r_busy;
    logic          r_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_chan     <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_clr      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_en    <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_clr      <= 1'b0;
            r_err      <= 1'b0;
            r_rd_en    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.dump_req) begin
                        if (bus.capture_done) begin
                            // Oldest sample sits just after the last written address.
                            r_state <= ST_RD;
                            r_chan  <= bus.dump_chan;
                            r_ptr   <= bus.trace_end + 1'b1;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RD: r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_tx_data  <= bus.ram_rdata;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: r_state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (bus.tx_done) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state <= ST_FINISH;
                            r_clr   <= 1'b1;
                        end else begin
                            r_state <= ST_RD;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    ram_port_mux #(
        .AW (AW)
    ) u_ram_port_mux (
        .i_dump_busy (r_busy),
        .i_cap_addr  (bus.cap_addr),
        .i_cap_en    (bus.cap_en),
        .i_cap_we    (bus.cap_we),
        .i_dump_addr (r_ptr),
        .i_dump_en   (r_rd_en),
        .o_ram_addr  (bus.ram_addr),
        .o_ram_en    (bus.ram_en),
        .o_ram_we    (bus.ram_we)
    );

    assign bus.ram_sel          = r_chan;
    assign bus.tx_data          = r_tx_data;
    assign bus.tx_start         = r_tx_start;
    assign bus.dump_busy        = r_busy;
    assign bus.clr_capture_done = r_clr;
    assign bus.dump_err         = r_err;

endmodule

`default_nettype wire
